// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler
//   Shares one start/done sensor reader between NUM_REQ requesters. A request
//   is arbitrated, the winner gets a one-hot grant and the reader gets a
//   one-cycle start pulse. The grant is held until the reader reports done or
//   the transaction times out. A free-running prescaler provides the tick that
//   paces the timeout.
//
//   Build option: define SCHED_FIXED_PRIORITY_EN to make the lowest-indexed
//   active request win every arbitration. Without it, arbitration is
//   round-robin starting after the last granted requester.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   req      in   level request per requester
//   done     in   reader finished (one-cycle pulse)
//   grant    out  one-hot owner of the reader, 0 when free
//   start    out  one-cycle pulse launching the reader
//   busy     out  high while a transaction is in progress (START/WAIT/RELEASE)
//   timeout  out  one-cycle pulse when a transaction is aborted
//   tick     out  one-cycle prescaler pulse
//
// FSM states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | reader free, waiting for any request
//   S_START   | grant issued, start pulse on the output this cycle
//   S_WAIT    | reader running, waiting for done or tick-based timeout
//   S_RELEASE | transaction over, grant dropped on the way back to IDLE

module sensor_poll_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int PRESCALE_MAX  = 49999,
  parameter int PRESCALE_SIZE = 16,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               start,
  output logic               busy,
  output logic               timeout,
  output logic               tick
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PRESCALE_SIZE-1:0] PRESC_TC = PRESCALE_SIZE'(PRESCALE_MAX);
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [PRESCALE_SIZE-1:0] presc_cnt;
  logic [7:0]               to_cnt;
  logic                     to_expire;

  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;

  logic [NUM_REQ-1:0]       grant_d;
  logic                     start_d;
  logic                     busy_d;
  logic                     timeout_d;

  // --------------------------------------------------------------------------
  // Prescaler: runs regardless of FSM state. tick is registered, so it is high
  // in the cycle after the terminal count was sampled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else if (presc_cnt == PRESC_TC) begin
      presc_cnt <= '0;
      tick      <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
      tick      <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Timeout timer: down-counter loaded in START with the number of ticks
  // allowed, decremented on each tick seen in WAIT. The transaction expires on
  // the tick that would take it from 1 to 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == S_START) begin
      to_cnt <= TO_LOAD;
    end else if ((state == S_WAIT) && tick && (to_cnt != 8'd0)) begin
      to_cnt <= to_cnt - 8'd1;
    end
  end

  assign to_expire = tick && (to_cnt == 8'd1);

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
`ifdef SCHED_FIXED_PRIORITY_EN

  // Lowest active index wins; scan from the top so the last hit is the lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

`else

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] cand_idx;

  // last_idx starts at NUM_REQ-1 so requester 0 is first in line after reset.
  // It only moves in RELEASE, so an aborted or completed owner both yield.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx  <= IDX_W'(NUM_REQ - 1);
      owner_idx <= '0;
    end else begin
      if ((state == S_IDLE) && win_found) begin
        owner_idx <= win_idx;
      end
      if (state == S_RELEASE) begin
        last_idx <= owner_idx;
      end
    end
  end

  // Offsets are scanned from farthest to nearest, so the nearest active
  // requester after last_idx is the final (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`endif

  // --------------------------------------------------------------------------
  // FSM: state and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      grant   <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= next_state;
      grant   <= grant_d;
      start   <= start_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. done wins over a coincident final tick.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          next_state = S_START;
        end
      end
      S_START: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (done || to_expire) begin
          next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, computed from the state being entered so they are valid in
  // that state's cycle. The grant stays registered through WAIT and RELEASE.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_d   = grant;
    start_d   = 1'b0;
    busy_d    = (next_state != S_IDLE);
    timeout_d = 1'b0;
    case (next_state)
      S_IDLE: begin
        grant_d = '0;
      end
      S_START: begin
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        start_d          = 1'b1;
      end
      S_WAIT: begin
        grant_d = grant;
      end
      S_RELEASE: begin
        grant_d = grant;
      end
      default: begin
        grant_d = '0;
      end
    endcase
    if ((state == S_WAIT) && !done && to_expire) begin
      timeout_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
module tb_sensor_poll_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       start;
  logic       busy;
  logic       timeout;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // tick model: next cycle (as seen at negedge) on which tick must be high
  int tick_next  = 0;
  bit tick_armed = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
  } exp_t;

  exp_t start_q[$];
  exp_t to_q[$];

  sensor_poll_scheduler #(
    .NUM_REQ      (4),
    .PRESCALE_MAX (3),
    .PRESCALE_SIZE(4),
    .TIMEOUT_TICKS(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .start  (start),
    .busy   (busy),
    .timeout(timeout),
    .tick   (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic push_start(input int c, input logic [3:0] g);
    exp_t e;
    e.cyc = c;
    e.grant = g;
    start_q.push_back(e);
  endtask

  task automatic push_to(input int c, input logic [3:0] g);
    exp_t e;
    e.cyc = c;
    e.grant = g;
    to_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT emits start or timeout,
  // checks the tick cadence and the grant encoding every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (start) begin
        if (start_q.size() == 0) begin
          chk("unexpected_start", 32'(grant), 32'h0);
        end else begin
          e = start_q.pop_front();
          chk("start_cyc", 32'(cyc), 32'(e.cyc));
          chk("start_grant", 32'(grant), 32'(e.grant));
        end
      end
      if (timeout) begin
        if (to_q.size() == 0) begin
          chk("unexpected_timeout", 32'(timeout), 32'h0);
        end else begin
          e = to_q.pop_front();
          chk("timeout_cyc", 32'(cyc), 32'(e.cyc));
          chk("timeout_grant", 32'(grant), 32'(e.grant));
        end
      end
      if (tick_armed && (tick || (cyc == tick_next))) begin
        chk("tick", 32'(tick), 32'(cyc == tick_next));
        if (cyc == tick_next) tick_next = tick_next + 4;
      end
      chk("grant_onehot0", 32'($onehot0(grant)), 32'h1);
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick_armed = 0;
    req = '0;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    tick_next = cyc + 4;
    tick_armed = 1;
  endtask

  // Holds rv for n transactions; done arrives 3 cycles after each start,
  // so starts fall every 6 cycles beginning at c+1.
  task automatic held_burst(input logic [3:0] rv, input int n);
    int c;
    c = cyc;
    req = rv;
    for (int k = 0; k < n; k++) begin
      at_cyc(c + 4 + 6 * k);
      done = 1'b1;
      at_cyc(c + 5 + 6 * k);
      done = 1'b0;
    end
    req = '0;
    at_cyc(c + 6 * n + 2);
    chk("burst_end_grant", 32'(grant), 32'h0);
    chk("burst_end_busy", 32'(busy), 32'h0);
  endtask

  logic [3:0] g_exp;
  logic [3:0] g6 [3];

  initial begin
    int c;
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;

    // Reset state, then reset asserted mid-transaction during a tick cycle.
    do_reset();
    c = cyc;
    req = 4'b0100;
    push_start(c + 1, 4'b0100);
    at_cyc(c + 1);
    req = '0;
    at_cyc(c + 4);
    chk("t1_busy_before", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    tick_armed = 0;
    #1;
    chk("t1_grant", 32'(grant), 32'h0);
    chk("t1_start", 32'(start), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_timeout", 32'(timeout), 32'h0);
    chk("t1_tick", 32'(tick), 32'h0);

    // Single request, done in cycle 6: grant held cycles 1..7.
    do_reset();
    c = cyc;
    req = 4'b0001;
    push_start(c + 1, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      at_cyc(c + k);
      g_exp = (k <= 7) ? 4'b0001 : 4'b0000;
      chk("t2_grant", 32'(grant), 32'(g_exp));
      chk("t2_start", 32'(start), 32'(k == 1));
      chk("t2_busy", 32'(busy), 32'(k <= 7));
      if (k == 1) req = '0;
      if (k == 6) done = 1'b1;
      if (k == 7) done = 1'b0;
    end

    // All four requesting: round-robin rotation from requester 0.
    do_reset();
    c = cyc;
    push_start(c + 1,  4'b0001);
    push_start(c + 7,  4'b0010);
    push_start(c + 13, 4'b0100);
    push_start(c + 19, 4'b1000);
    push_start(c + 25, 4'b0001);
    held_burst(4'b1111, 5);

    // Timeout: ticks at c+4, c+8 fall in WAIT, pulse at c+9, grant gone c+10.
    do_reset();
    c = cyc;
    at_cyc(c + 1);
    req = 4'b0001;
    push_start(c + 2, 4'b0001);
    push_to(c + 9, 4'b0001);
    at_cyc(c + 2);
    req = '0;
    at_cyc(c + 9);
    chk("t4_busy_release", 32'(busy), 32'h1);
    at_cyc(c + 10);
    chk("t4_grant_cleared", 32'(grant), 32'h0);
    chk("t4_busy_cleared", 32'(busy), 32'h0);
    chk("t4_timeout_once", 32'(timeout), 32'h0);

    // done coincident with the second WAIT tick (c+20): no timeout pulse.
    at_cyc(c + 13);
    req = 4'b0001;
    push_start(c + 14, 4'b0001);
    at_cyc(c + 14);
    req = '0;
    at_cyc(c + 20);
    chk("t5_tick_with_done", 32'(tick), 32'h1);
    done = 1'b1;
    at_cyc(c + 21);
    done = 1'b0;
    chk("t5_no_timeout", 32'(timeout), 32'h0);
    chk("t5_release_grant", 32'(grant), 32'h1);
    chk("t5_release_busy", 32'(busy), 32'h1);
    at_cyc(c + 22);
    chk("t5_idle_grant", 32'(grant), 32'h0);

    // req=1010 held: fixed priority always picks 1, round-robin alternates.
`ifdef SCHED_FIXED_PRIORITY_EN
    g6[0] = 4'b0010; g6[1] = 4'b0010; g6[2] = 4'b0010;
`else
    g6[0] = 4'b0010; g6[1] = 4'b1000; g6[2] = 4'b0010;
`endif
    do_reset();
    c = cyc;
    for (int k = 0; k < 3; k++) push_start(c + 1 + 6 * k, g6[k]);
    held_burst(4'b1010, 3);

    repeat (3) @(negedge clk);
    chk("start_q_drained", 32'(start_q.size()), 32'h0);
    chk("to_q_drained", 32'(to_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
